// File: rtl/rv0_fpu_pkg.sv
// Shared FP writeback definitions: CSR addresses, flag bundle,
// CSR op and rounding-mode encodings.
package rv0_fpu_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  function automatic logic [7:0] csr_apply(
    input csr_op_e    op,
    input logic [7:0] old,
    input logic [7:0] wd
  );
    logic [7:0] r;
    r = old;
    unique case (op)
      CSR_READ:  r = old;
      CSR_WRITE: r = wd;
      CSR_SET:   r = old | wd;
      CSR_CLEAR: r = old & ~wd;
      default:   r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv0_fcsr.sv
// fflags/frm state and the IDLE/ACK CSR access FSM.
// Requests wait while busy_i so flag accumulation stays ordered.
module rv0_fcsr
  import rv0_fpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        retire_i,
  input  logic [4:0]  ret_flags_i,
  input  logic        busy_i,
  input  logic        csr_req_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_ack_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  output logic [2:0]  frm_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  state_e      r_state;
  fflags_t     r_fflags;
  logic [2:0]  r_frm;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_hit_ff;
  logic        w_hit_rm;
  logic        w_hit_cs;
  logic        w_err;
  logic        w_take;
  logic [7:0]  w_old;
  logic [7:0]  w_new;
  logic        w_unused_wdata;

  assign w_hit_ff = csr_addr_i == CSR_FFLAGS;
  assign w_hit_rm = csr_addr_i == CSR_FRM;
  assign w_hit_cs = csr_addr_i == CSR_FCSR;
  assign w_err    = !(w_hit_ff || w_hit_rm || w_hit_cs);
  assign w_take   = (r_state == S_IDLE) && csr_req_i && !busy_i;

  assign w_unused_wdata = &{1'b0, csr_wdata_i[31:8]};

  always_comb begin
    w_old = 8'h00;
    unique case (1'b1)
      w_hit_ff: w_old = {3'b000, r_fflags};
      w_hit_rm: w_old = {5'b00000, r_frm};
      w_hit_cs: w_old = {r_frm, r_fflags};
      default:  w_old = 8'h00;
    endcase
  end

  assign w_new = csr_apply(csr_op_e'(csr_op_i), w_old,
                           csr_wdata_i[7:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_fflags <= '0;
      r_frm    <= 3'b000;
      r_ack    <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (retire_i)
        r_fflags <= r_fflags | fflags_t'(ret_flags_i);
      unique case (r_state)
        S_IDLE: begin
          r_ack   <= 1'b0;
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
          if (w_take) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= {24'h0, w_old};
            unique case (1'b1)
              w_hit_ff: r_fflags <= fflags_t'(w_new[4:0]);
              w_hit_rm: r_frm    <= w_new[2:0];
              w_hit_cs: begin
                r_frm    <= w_new[7:5];
                r_fflags <= fflags_t'(w_new[4:0]);
              end
              default: ;
            endcase
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign csr_ack_o   = r_ack;
  assign csr_rdata_o = r_rdata;
  assign csr_err_o   = r_err;
  assign frm_o       = r_frm;

endmodule

// File: rtl/rv0_fpu_wb.sv
// FP writeback: one-entry result register feeding the FP regfile.
// Optional forwarding ports under RV0_FPU_WB_BYPASS_EN.
module rv0_fpu_wb
  import rv0_fpu_pkg::*;
#(
  parameter int FLEN = 32,
  parameter int NREG = 32,
  localparam int RDW = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_valid_i,
  output logic            wb_ready_o,
  input  logic [RDW-1:0]  wb_rd_i,
  input  logic [FLEN-1:0] wb_wdata_i,
  input  logic [4:0]      wb_fflags_i,
  input  logic [2:0]      wb_rm_i,
  output logic            rf_we_o,
  output logic [RDW-1:0]  rf_waddr_o,
  output logic [FLEN-1:0] rf_wdata_o,
  input  logic            rf_ready_i,
  output logic [2:0]      frm_o,
  output logic            rm_illegal_o,
`ifdef RV0_FPU_WB_BYPASS_EN
  output logic            byp_valid_o,
  output logic [RDW-1:0]  byp_rd_o,
  output logic [FLEN-1:0] byp_data_o,
`endif
  input  logic            csr_req_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [31:0]     csr_wdata_i,
  output logic            csr_ack_o,
  output logic [31:0]     csr_rdata_o,
  output logic            csr_err_o
);

  logic            r_valid;
  logic [RDW-1:0]  r_rd;
  logic [FLEN-1:0] r_data;
  fflags_t         r_flags;

  logic            w_accept;
  logic            w_retire;
  logic            w_busy;
  logic [2:0]      w_frm;

  assign wb_ready_o = !r_valid || rf_ready_i;
  assign w_accept   = wb_valid_i && wb_ready_o;
  assign w_retire   = r_valid && rf_ready_i;
  assign w_busy     = r_valid || w_accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_rd    <= wb_rd_i;
      r_data  <= wb_wdata_i;
      r_flags <= fflags_t'(wb_fflags_i);
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

  assign rf_we_o    = r_valid;
  assign rf_waddr_o = r_rd;
  assign rf_wdata_o = r_data;

  // 101/110 are reserved; DYN is only usable when frm itself is legal
  assign rm_illegal_o = (wb_rm_i == 3'b101) ||
                        (wb_rm_i == 3'b110) ||
                        ((wb_rm_i == RM_DYN) &&
                         (w_frm > RM_RMM));

`ifdef RV0_FPU_WB_BYPASS_EN
  assign byp_valid_o = r_valid;
  assign byp_rd_o    = r_rd;
  assign byp_data_o  = r_data;
`endif

  rv0_fcsr u_fcsr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .retire_i    (w_retire),
    .ret_flags_i (r_flags),
    .busy_i      (w_busy),
    .csr_req_i   (csr_req_i),
    .csr_addr_i  (csr_addr_i),
    .csr_op_i    (csr_op_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_ack_o   (csr_ack_o),
    .csr_rdata_o (csr_rdata_o),
    .csr_err_o   (csr_err_o),
    .frm_o       (w_frm)
  );

  assign frm_o = w_frm;

endmodule

// File: tb/tb_rv0_fpu_wb.sv
// Directed bench for rv0_fpu_wb with an rf-write scoreboard
// and bounded CSR access task.
module tb_rv0_fpu_wb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_wdata_i;
  logic [4:0]  wb_fflags_i;
  logic [2:0]  wb_rm_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_ready_i;
  logic [2:0]  frm_o;
  logic        rm_illegal_o;
  logic        csr_req_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic        csr_ack_o;
  logic [31:0] csr_rdata_o;
  logic        csr_err_o;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  rv0_fpu_wb dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wb_valid_i   (wb_valid_i),
    .wb_ready_o   (wb_ready_o),
    .wb_rd_i      (wb_rd_i),
    .wb_wdata_i   (wb_wdata_i),
    .wb_fflags_i  (wb_fflags_i),
    .wb_rm_i      (wb_rm_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_ready_i   (rf_ready_i),
    .frm_o        (frm_o),
    .rm_illegal_o (rm_illegal_o),
    .csr_req_i    (csr_req_i),
    .csr_addr_i   (csr_addr_i),
    .csr_op_i     (csr_op_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_ack_o    (csr_ack_o),
    .csr_rdata_o  (csr_rdata_o),
    .csr_err_o    (csr_err_o)
  );

  task automatic chk(input string tag, input logic [36:0] obs,
                     input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every regfile write the DUT retires must match the oldest push
  always @(negedge clk) begin
    if (!rst_i && rf_we_o && rf_ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {rf_waddr_o, rf_wdata_o}, '0);
      end else begin
        chk("sb_write", {rf_waddr_o, rf_wdata_o}, sb.pop_front());
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] d,
                      input logic [4:0] f, input logic expect_wr);
    wb_valid_i  = 1'b1;
    wb_rd_i     = rd;
    wb_wdata_i  = d;
    wb_fflags_i = f;
    if (expect_wr) sb.push_back({rd, d});
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic err, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    csr_req_i   = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = a;
    csr_wdata_i = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (csr_ack_o) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    rd  = csr_rdata_o;
    err = csr_err_o;
    if (!got) chk("csr_ack_timeout", 37'd0, 37'd1);
    step();
    csr_req_i = 1'b0;
  endtask

  logic [31:0] rdv;
  logic        errv;
  int          wt;

  initial begin
    rst_i = 1'b1;
    wb_valid_i = 1'b0;
    wb_rd_i = '0;
    wb_wdata_i = '0;
    wb_fflags_i = '0;
    wb_rm_i = 3'b000;
    rf_ready_i = 1'b1;
    csr_req_i = 1'b0;
    csr_addr_i = '0;
    csr_op_i = '0;
    csr_wdata_i = '0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 37'(wb_ready_o), 37'd1);
    chk("rst_we", 37'(rf_we_o), 37'd0);
    chk("rst_frm", 37'(frm_o), 37'd0);
    chk("rst_ack", {csr_ack_o, csr_err_o, csr_rdata_o}, '0);
    chk("rst_rf", {rf_waddr_o, rf_wdata_o}, '0);

    // single accept then retire
    step();
    push(5'd3, 32'h40000000, 5'b00000, 1'b1);
    step();
    wb_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_we", 37'(rf_we_o), 37'd1);
    chk("t1_rf", {rf_waddr_o, rf_wdata_o}, {5'd3, 32'h40000000});
    step();
    csr(2'b00, 12'h001, 32'h0, rdv, errv, wt);
    chk("t1_fflags", 37'(rdv), 37'h0);

    // stall three cycles, then retire + accept together
    rf_ready_i = 1'b0;
    push(5'd5, 32'h11111111, 5'b10000, 1'b1);
    step();
    wb_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_ready", 37'(wb_ready_o), 37'd0);
      chk("t2_stall_rf", {rf_we_o, rf_waddr_o, rf_wdata_o[30:0]},
          {1'b1, 5'd5, 31'h11111111});
      step();
    end
    rf_ready_i = 1'b1;
    push(5'd6, 32'h22222222, 5'b00001, 1'b1);
    @(negedge clk);
    chk("t2_ready_on_retire", 37'(wb_ready_o), 37'd1);
    step();
    wb_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_next", {rf_waddr_o, rf_wdata_o}, {5'd6, 32'h22222222});
    step();

    // flag accumulation and fcsr write
    csr(2'b00, 12'h001, 32'h0, rdv, errv, wt);
    chk("t3_fflags", {errv, rdv}, 33'h011);
    csr(2'b01, 12'h003, 32'h000000E0, rdv, errv, wt);
    chk("t3_fcsr_wr_old", 37'(rdv), 37'h11);
    csr(2'b00, 12'h003, 32'h0, rdv, errv, wt);
    chk("t3_fcsr_rd", 37'(rdv), 37'hE0);
    chk("t3_frm_o", 37'(frm_o), 37'd7);

    // rounding-mode legality
    csr(2'b01, 12'h002, 32'hFFFFFFFD, rdv, errv, wt);
    chk("t4_frm_old", 37'(rdv), 37'd7);
    chk("t4_frm_new", 37'(frm_o), 37'd5);
    wb_rm_i = 3'b111;
    @(negedge clk);
    chk("t4_dyn_bad", 37'(rm_illegal_o), 37'd1);
    step();
    wb_rm_i = 3'b000;
    @(negedge clk);
    chk("t4_rne", 37'(rm_illegal_o), 37'd0);
    step();
    wb_rm_i = 3'b110;
    @(negedge clk);
    chk("t4_rsv", 37'(rm_illegal_o), 37'd1);
    step();
    csr(2'b01, 12'h002, 32'h4, rdv, errv, wt);
    wb_rm_i = 3'b111;
    @(negedge clk);
    chk("t4_dyn_ok", 37'(rm_illegal_o), 37'd0);
    step();
    wb_rm_i = 3'b000;

    // CSR clear while an entry is pending waits for its retire
    rf_ready_i = 1'b0;
    push(5'd7, 32'h33333333, 5'b00100, 1'b1);
    step();
    wb_valid_i = 1'b0;
    fork
      csr(2'b11, 12'h001, 32'h00000004, rdv, errv, wt);
      begin
        repeat (3) step();
        rf_ready_i = 1'b1;
      end
    join
    chk("t5_clear_old", 37'(rdv), 37'h04);
    chk("t5_waited", 37'(wt >= 3), 37'd1);
    csr(2'b10, 12'h001, 32'hFFFFFF03, rdv, errv, wt);
    chk("t5_set_old", 37'(rdv), 37'h00);
    csr(2'b00, 12'h003, 32'h0, rdv, errv, wt);
    chk("t5_fcsr", 37'(rdv), 37'h83);

    // unsupported address
    csr(2'b01, 12'h300, 32'hFF, rdv, errv, wt);
    chk("t6_err", {errv, rdv}, 33'h1_0000_0000);
    csr(2'b00, 12'h003, 32'h0, rdv, errv, wt);
    chk("t6_unchanged", 37'(rdv), 37'h83);

    // reset with an entry held drops it
    rf_ready_i = 1'b0;
    push(5'd9, 32'h55555555, 5'b11111, 1'b0);
    step();
    wb_valid_i = 1'b0;
    @(negedge clk);
    chk("t7_held", 37'(rf_we_o), 37'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("t7_we", 37'(rf_we_o), 37'd0);
    chk("t7_frm", 37'(frm_o), 37'd0);
    chk("t7_ready", 37'(wb_ready_o), 37'd1);
    rf_ready_i = 1'b1;
    step();
    csr(2'b00, 12'h003, 32'h0, rdv, errv, wt);
    chk("t7_fcsr", 37'(rdv), 37'h0);

    step();
    chk("sb_drained", 37'(sb.size()), 37'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv0_fpu_wb.md
Name: rv0_fpu_wb

Overview:
- Writeback stage directly downstream of the combinational FP ALU, rv0_alu_f.
- Registers one ALU result per handshake and drives the FP register-file write port.
- Accumulates the ALU's 5-bit exception flags into the architectural fcsr.
- Serves CSR accesses to fflags (0x001), frm (0x002) and fcsr (0x003), and supplies frm back to the ALU.

Parameters:
- FLEN, 32, FP data width.
- NREG, 32, FP register count; rd width = $clog2(NREG).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- wb_valid_i  in  1  ALU result valid.
- wb_ready_o  out  1  stage can accept.
- wb_rd_i  in  5  destination register.
- wb_wdata_i  in  FLEN  result (alu_f_wdata_o).
- wb_fflags_i  in  5  flags NV,DZ,OF,UF,NX (ALU fflags).
- wb_rm_i  in  3  insn rm field.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  write address.
- rf_wdata_o  out  FLEN  write data.
- rf_ready_i  in  1  write port granted (shared with load unit).
- frm_o  out  3  current frm.
- rm_illegal_o  out  1  wb_rm_i is unusable.
- csr_req_i  in  1  CSR access request.
- csr_addr_i  in  12  CSR address.
- csr_op_i  in  2  00 read, 01 write, 10 set, 11 clear.
- csr_wdata_i  in  32  operand.
- csr_ack_o  out  1  access done.
- csr_rdata_o  out  32  old CSR value, zero-extended.
- csr_err_o  out  1  unsupported address.

Behaviour:
- Reset (synchronous, active-high): valid_q=0, fflags=0, frm=0. All outputs 0, except wb_ready_o=1 on the first cycle after reset.
- Reset asserted mid-operation drops any held entry; no rf write occurs for it.
- One-entry pipeline register.
  - wb_ready_o = !valid_q || rf_ready_i.
  - Accept when wb_valid_i && wb_ready_o.
  - Accepted data appears on rf_* on the next cycle.
- rf_we_o = valid_q. It holds, with rf_waddr_o and rf_wdata_o stable, until rf_ready_i.
- Retire = valid_q && rf_ready_i.
  - On retire, fflags |= held flags.
  - Accept in the same cycle as a retire gives full throughput of 1 per cycle.
- rm_illegal_o is combinational. It is 1 when:
  - wb_rm_i is 101 or 110; or
  - wb_rm_i is 111 and frm >= 101.
- CSR FSM has states IDLE and ACK.
  - IDLE: a request is taken only when valid_q=0 && !(wb_valid_i && wb_ready_o). This keeps flags ordered. Otherwise the request waits; the requester holds csr_req_i.
  - Taking a request moves to ACK.
  - ACK: csr_ack_o=1 for exactly one cycle, csr_rdata_o = value before the op. Return to IDLE.
- Per-address behaviour:
  - fflags: 5 bits.
  - frm: 3 bits.
  - fcsr: {frm, fflags}.
  - Unused bits read 0; writes to them are ignored.
  - Set ORs csr_wdata_i in; clear ANDs its inverse in.
- Any other address: ack with csr_err_o=1, rdata=0, no state change.
- A retire in the same cycle as a CSR update cannot occur, because the gating rule above prevents it.

Optional Feature:
- Macro: RV0_FPU_WB_BYPASS_EN.
- When defined, adds outputs:
  - byp_valid_o = valid_q;
  - byp_rd_o = held rd;
  - byp_data_o = held data.
- These let the decode stage forward a pending result.
- When undefined, the ports are absent and no forwarding logic is built.

Decomposition:
- Package rv0_fpu_pkg holds:
  - CSR address constants CSR_FFLAGS, CSR_FRM, CSR_FCSR;
  - typedef fflags_t (packed nv,dz,of,uf,nx);
  - enum csr_op_e;
  - rounding-mode enum rm_e (RNE..RMM, DYN=111).
- One sub-module, rv0_fcsr, contains the fflags/frm registers and the CSR FSM.
- rv0_fpu_wb contains the pipeline register and the handshake.

Test Plan:
- Accept rd=3, data 40000000, flags 00000 with rf_ready_i=1 → next cycle rf_we_o=1, waddr=3, wdata=40000000; fflags remains 0.
- Hold rf_ready_i=0 for 3 cycles with a pending entry → wb_ready_o=0, rf_* stable; release → retire and accept in the same cycle.
- Retire flags 10000, then 00001 → fflags read returns 10001; fcsr write 0xE0 then read → 0xE0, frm_o=111.
- frm=101 with wb_rm_i=111 → rm_illegal_o=1; wb_rm_i=000 → rm_illegal_o=0.
- CSR clear of fflags issued while an entry is pending → ack delayed until retire; rdata includes that entry's flags.
- csr_addr 0x300 → csr_ack_o=1, csr_err_o=1, rdata=0; assert rst_i with an entry held → rf_we_o=0 next cycle, fcsr=0.
